awb_gain_gen: RTL and testbench

//  Gray-world auto-white-balance gain generator; produces K_R/K_G/K_B + valid_gain for the WB stage.

---
 rtl/awb_gain_gen_pkg.sv | 17 +
 rtl/awb_gain_gen_div.sv | 77 +++++++
 rtl/awb_gain_gen.sv | 169 ++++++++++++++++
 tb/tb_awb_gain_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/awb_gain_gen_pkg.sv
// Shared definitions for the gray-world AWB gain generator.
package awb_gain_gen_pkg;

  localparam int          GAIN_W      = 16;
  localparam logic [1:0]  COLOR_RED   = 2'd0;
  localparam logic [1:0]  COLOR_GREEN = 2'd1;
  localparam logic [1:0]  COLOR_BLUE  = 2'd2;
  localparam logic [15:0] UNITY_GAIN  = 16'h0100;

  typedef enum logic [1:0] {
    ACCUM,
    DIV_R,
    DIV_B,
    UPDATE
  } awb_state_e;

endpackage

// File: rtl/awb_gain_gen_div.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// The start cycle already retires the first quotient bit, so a divide takes N cycles.
module awb_div #(
  parameter int N = 32,
  parameter int D = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [D-1:0] i_divisor,
  output logic         o_done,
  output logic [N-1:0] o_quotient,
  output logic         o_div_by_zero
);

  localparam int CW = $clog2(N + 1);

  logic [D-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [CW-1:0] r_cnt;
  logic          r_active;
  logic          r_done;
  logic          r_dz;

  logic [D-1:0]  w_rem_src;
  logic [N-1:0]  w_quo_src;
  logic [D:0]    w_shift;
  logic          w_ge;
  logic [D-1:0]  w_rem_nxt;
  logic [N-1:0]  w_quo_nxt;

  // The divisor is held steady by the caller for the whole divide.
  always_comb begin
    w_rem_src = i_start ? '0 : r_rem;
    w_quo_src = i_start ? i_dividend : r_quo;
    w_shift   = {w_rem_src, w_quo_src[N-1]};
    w_ge      = (w_shift >= {1'b0, i_divisor});
    w_rem_nxt = w_ge ? D'(w_shift - {1'b0, i_divisor}) : w_shift[D-1:0];
    w_quo_nxt = {w_quo_src[N-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else if (i_start) begin
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_cnt    <= CW'(N - 1);
      r_active <= 1'b1;
      r_done   <= 1'b0;
      r_dz     <= (i_divisor == '0);
    end else if (r_active) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_active <= 1'b0;
        r_done   <= 1'b1;
      end else begin
        r_done   <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done        = r_done;
  assign o_quotient    = r_quo;
  assign o_div_by_zero = r_dz;

endmodule

// File: rtl/awb_gain_gen.sv
// Gray-world AWB gain generator: per-frame channel sums, then K_R = G/R and K_B = G/B in 8.8.
module awb_gain_gen
  import awb_gain_gen_pkg::*;
#(
  parameter int          ACC_W   = 24,
  parameter int          G_SHIFT = 1,
  parameter logic [15:0] K_MAX   = 16'h0FFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [1:0]        color_i,
  input  logic [7:0]        value_i,
  input  logic              last_i,
  output logic [GAIN_W-1:0] K_R,
  output logic [GAIN_W-1:0] K_G,
  output logic [GAIN_W-1:0] K_B,
  output logic              valid_gain_o,
  output logic              busy_o,
  output logic              drop_o
);

  localparam int DW = ACC_W + 8;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [7:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W-7){1'b0}}, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  function automatic logic [GAIN_W-1:0] clamp_gain(input logic [DW-1:0] q, input logic dz);
    if (dz)                 return UNITY_GAIN;
    else if (q > DW'(K_MAX)) return K_MAX;
    else                    return q[GAIN_W-1:0];
  endfunction

  logic             r_valid;
  logic [1:0]       r_color;
  logic [7:0]       r_value;
  logic             r_last;
  logic [ACC_W-1:0] r_acc_r, r_acc_g, r_acc_b;
  logic [ACC_W-1:0] r_snap_r, r_snap_g, r_snap_b;
  logic [GAIN_W-1:0] r_kr_calc, r_kb_calc;
  logic             r_drop;
  awb_state_e       r_state, w_state_nxt;

  logic [ACC_W-1:0] w_sum_r, w_sum_g, w_sum_b;
  logic             w_frame_end;
  logic             w_busy;
  logic             w_start, w_cap_r, w_cap_b, w_upd;
  logic [ACC_W-1:0] w_g_src;
  logic [ACC_W-1:0] w_divisor;
  logic [DW-1:0]    w_dividend;
  logic             w_div_done;
  logic [DW-1:0]    w_quotient;
  logic             w_div_dz;

  // Sums include the current registered pixel so the frame-end pixel lands in the snapshot.
  always_comb begin
    w_sum_r = (r_valid && r_color == COLOR_RED)   ? sat_add(r_acc_r, r_value) : r_acc_r;
    w_sum_g = (r_valid && r_color == COLOR_GREEN) ? sat_add(r_acc_g, r_value) : r_acc_g;
    w_sum_b = (r_valid && r_color == COLOR_BLUE)  ? sat_add(r_acc_b, r_value) : r_acc_b;
  end

  assign w_frame_end = r_valid & r_last;
  assign w_busy      = (r_state != ACCUM);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_cap_r     = 1'b0;
    w_cap_b     = 1'b0;
    w_upd       = 1'b0;
    case (r_state)
      ACCUM: if (w_frame_end) begin
        w_start     = 1'b1;
        w_state_nxt = DIV_R;
      end
      DIV_R: if (w_div_done) begin
        w_cap_r     = 1'b1;
        w_start     = 1'b1;
        w_state_nxt = DIV_B;
      end
      DIV_B: if (w_div_done) begin
        w_cap_b     = 1'b1;
        w_state_nxt = UPDATE;
      end
      UPDATE: begin
        w_upd       = 1'b1;
        w_state_nxt = ACCUM;
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  // Red starts on the frame-end cycle itself, before the snapshot registers have loaded.
  always_comb begin
    w_g_src    = (r_state == ACCUM) ? w_sum_g : r_snap_g;
    w_dividend = {w_g_src >> G_SHIFT, 8'h00};
    if (w_start) w_divisor = (r_state == ACCUM) ? w_sum_r : r_snap_b;
    else         w_divisor = (r_state == DIV_R) ? r_snap_r : r_snap_b;
  end

  awb_div #(.N(DW), .D(ACC_W)) u_div (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (w_start),
    .i_dividend    (w_dividend),
    .i_divisor     (w_divisor),
    .o_done        (w_div_done),
    .o_quotient    (w_quotient),
    .o_div_by_zero (w_div_dz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_color      <= '0;
      r_value      <= '0;
      r_last       <= 1'b0;
      r_acc_r      <= '0;
      r_acc_g      <= '0;
      r_acc_b      <= '0;
      r_snap_r     <= '0;
      r_snap_g     <= '0;
      r_snap_b     <= '0;
      r_kr_calc    <= UNITY_GAIN;
      r_kb_calc    <= UNITY_GAIN;
      r_drop       <= 1'b0;
      r_state      <= ACCUM;
      K_R          <= UNITY_GAIN;
      K_B          <= UNITY_GAIN;
      valid_gain_o <= 1'b0;
    end else begin
      r_valid <= valid_i;
      r_color <= color_i;
      r_value <= value_i;
      r_last  <= last_i;
      r_state <= w_state_nxt;
      r_drop  <= w_frame_end & w_busy;
      if (w_frame_end) begin
        r_acc_r <= '0;
        r_acc_g <= '0;
        r_acc_b <= '0;
      end else begin
        r_acc_r <= w_sum_r;
        r_acc_g <= w_sum_g;
        r_acc_b <= w_sum_b;
      end
      if (w_frame_end && !w_busy) begin
        r_snap_r <= w_sum_r;
        r_snap_g <= w_sum_g;
        r_snap_b <= w_sum_b;
      end
      if (w_cap_r) r_kr_calc <= clamp_gain(w_quotient, w_div_dz);
      if (w_cap_b) r_kb_calc <= clamp_gain(w_quotient, w_div_dz);
      if (w_upd) begin
        K_R          <= r_kr_calc;
        K_B          <= r_kb_calc;
        valid_gain_o <= 1'b1;
      end
    end
  end

  assign K_G    = UNITY_GAIN;
  assign busy_o = w_busy;
  assign drop_o = r_drop;

endmodule

// File: tb/tb_awb_gain_gen.sv
// Directed bench for awb_gain_gen: reset, neutral/cast/clamp frames, overlap drop, mid-divide reset.
module tb_awb_gain_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  color_i = 2'd0;
  logic [7:0]  value_i = 8'd0;
  logic        last_i = 1'b0;
  logic [15:0] K_R, K_G, K_B;
  logic        valid_gain_o, busy_o, drop_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] cur_kr = 16'h0100;
  logic [15:0] cur_kb = 16'h0100;
  logic        cur_valid = 1'b0;

  awb_gain_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .color_i      (color_i),
    .value_i      (value_i),
    .last_i       (last_i),
    .K_R          (K_R),
    .K_G          (K_G),
    .K_B          (K_B),
    .valid_gain_o (valid_gain_o),
    .busy_o       (busy_o),
    .drop_o       (drop_o)
  );

  always #5 clk = ~clk;

  task automatic send_px(input logic [1:0] c, input logic [7:0] v, input logic l);
    @(negedge clk);
    valid_i = 1'b1;
    color_i = c;
    value_i = v;
    last_i  = l;
  endtask

  task automatic send_frame(input logic [7:0] r, g1, g2, b, input bit c3_last);
    send_px(2'd0, r, 1'b0);
    send_px(2'd1, g1, 1'b0);
    send_px(2'd1, g2, 1'b0);
    if (c3_last) begin
      send_px(2'd2, b, 1'b0);
      send_px(2'd3, 8'd255, 1'b1);
    end else begin
      send_px(2'd2, b, 1'b1);
    end
  endtask

  task automatic run_frame(input logic [7:0] r, g1, g2, b, input bit c3_last,
                           input logic [15:0] ekr, ekb, input string name);
    send_frame(r, g1, g2, b, c3_last);
    for (int k = 1; k <= 67; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin valid_i = 1'b0; last_i = 1'b0; end
      if (k == 2) begin
        n_tests++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL %s busy_start: got %b want 1", name, busy_o); end
      end
      if (k == 66) begin
        n_tests++;
        if (K_R !== cur_kr) begin n_fail++; $display("FAIL %s kr_early: got %h want %h", name, K_R, cur_kr); end
        n_tests++;
        if (valid_gain_o !== cur_valid) begin n_fail++; $display("FAIL %s valid_early: got %b want %b", name, valid_gain_o, cur_valid); end
      end
      if (k == 67) begin
        n_tests++;
        if (K_R !== ekr) begin n_fail++; $display("FAIL %s kr: got %h want %h", name, K_R, ekr); end
        n_tests++;
        if (K_B !== ekb) begin n_fail++; $display("FAIL %s kb: got %h want %h", name, K_B, ekb); end
        n_tests++;
        if (K_G !== 16'h0100) begin n_fail++; $display("FAIL %s kg: got %h want 0100", name, K_G); end
        n_tests++;
        if (valid_gain_o !== 1'b1) begin n_fail++; $display("FAIL %s valid: got %b want 1", name, valid_gain_o); end
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s busy_end: got %b want 0", name, busy_o); end
      end
    end
    cur_kr = ekr;
    cur_kb = ekb;
    cur_valid = 1'b1;
  endtask

  task automatic test_reset;
    int seen;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (K_R !== 16'h0100) begin n_fail++; $display("FAIL rst_kr: got %h want 0100", K_R); end
    n_tests++;
    if (K_G !== 16'h0100) begin n_fail++; $display("FAIL rst_kg: got %h want 0100", K_G); end
    n_tests++;
    if (K_B !== 16'h0100) begin n_fail++; $display("FAIL rst_kb: got %h want 0100", K_B); end
    n_tests++;
    if (valid_gain_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_gain_o); end
    n_tests++;
    if (busy_o !== 1'b0 || drop_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy_drop: got %b%b want 00", busy_o, drop_o); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (valid_gain_o !== 1'b0 || busy_o !== 1'b0 || K_R !== 16'h0100) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL idle_no_update: got %0d bad cycles want 0", seen); end
  endtask

  task automatic test_neutral;
    run_frame(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 16'h0100, 16'h0100, "neutral");
  endtask

  task automatic test_cast;
    run_frame(8'd50, 8'd100, 8'd100, 8'd200, 1'b1, 16'h0200, 16'h0080, "cast_c3last");
  endtask

  task automatic test_clamp_zero;
    run_frame(8'd1, 8'd255, 8'd255, 8'd0, 1'b0, 16'h0FFF, 16'h0100, "clamp_zero");
  endtask

  task automatic test_overlap;
    int drops, busy_seen;
    send_frame(8'd50, 8'd100, 8'd100, 8'd200, 1'b0);
    drops = 0;
    for (int k = 1; k <= 67; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin valid_i = 1'b0; last_i = 1'b0; end
      if (k == 10) begin valid_i = 1'b1; color_i = 2'd0; value_i = 8'd7; last_i = 1'b1; end
      if (k == 11) begin valid_i = 1'b0; last_i = 1'b0; end
      if (drop_o === 1'b1) drops++;
      if (k == 12) begin
        n_tests++;
        if (drop_o !== 1'b1) begin n_fail++; $display("FAIL ovl_drop_pulse: got %b want 1", drop_o); end
      end
      if (k == 67) begin
        n_tests++;
        if (K_R !== 16'h0200) begin n_fail++; $display("FAIL ovl_kr: got %h want 0200", K_R); end
        n_tests++;
        if (K_B !== 16'h0080) begin n_fail++; $display("FAIL ovl_kb: got %h want 0080", K_B); end
      end
    end
    n_tests++;
    if (drops != 1) begin n_fail++; $display("FAIL ovl_drop_count: got %0d want 1", drops); end
    busy_seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (busy_o !== 1'b0) busy_seen++;
    end
    n_tests++;
    if (busy_seen != 0) begin n_fail++; $display("FAIL ovl_no_extra_div: got %0d busy cycles want 0", busy_seen); end
    cur_kr = 16'h0200;
    cur_kb = 16'h0080;
  endtask

  task automatic test_reset_mid_div;
    send_frame(8'd1, 8'd255, 8'd255, 8'd0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin valid_i = 1'b0; last_i = 1'b0; end
    end
    n_tests++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy_o); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (K_R !== 16'h0100 || K_B !== 16'h0100) begin n_fail++; $display("FAIL mid_rst_k: got %h/%h want 0100/0100", K_R, K_B); end
    n_tests++;
    if (valid_gain_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: got %b%b want 00", valid_gain_o, busy_o); end
    @(negedge clk);
    rst_n = 1'b1;
    cur_kr = 16'h0100;
    cur_kb = 16'h0100;
    cur_valid = 1'b0;
    run_frame(8'd50, 8'd100, 8'd100, 8'd200, 1'b0, 16'h0200, 16'h0080, "post_reset");
  endtask

  initial begin
    test_reset();
    test_neutral();
    test_cast();
    test_clamp_zero();
    test_overlap();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
